// File: rtl/clk_out_monitor.sv
// clk_out_monitor: frequency and duty-cycle monitor for a divided clock.
// The divided clock is sampled as data in the sys_clk domain; each period and
// high time is measured in sys_clk cycles and checked against EXP_PERIOD.
// Ports:
//   sys_clk, sys_rst  - system clock, synchronous active-high reset
//   clk_in            - divided clock under test (asynchronous data)
//   meas_en           - monitor enable, low returns to idle
//   err_clr           - pulse clearing the sticky error flags
//   period, high_time - last measured period / high time (sys_clk cycles)
//   meas_valid        - one-cycle pulse when period/high_time update
//   locked            - LOCK_CNT consecutive good measurements seen
//   err_period, err_duty, err_stuck - sticky error flags
module clk_out_monitor #(
  parameter int unsigned EXP_PERIOD = 7,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             clk_in,
  input  logic             meas_en,
  input  logic             err_clr,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             err_period,
  output logic             err_duty,
  output logic             err_stuck
);

  localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);

  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  EXP_P    = CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W-1:0]  HI_LO    = CNT_W'(EXP_PERIOD >> 1);
  localparam logic [CNT_W-1:0]  HI_HI    = CNT_W'((EXP_PERIOD + 1) >> 1);
  localparam logic [CNT_W-1:0]  TMO      = CNT_W'(TIMEOUT);
  localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_CNT);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_EDGE = 2'd1,
    ST_MEASURE   = 2'd2
  } state_t;

  // Registers
  logic              r_s1, r_s2, r_s3;
  state_t            r_state;
  logic [CNT_W-1:0]  r_per_cnt;
  logic [CNT_W-1:0]  r_hi_cnt;
  logic [GOOD_W-1:0] r_good_cnt;
  logic [CNT_W-1:0]  r_period;
  logic [CNT_W-1:0]  r_high_time;
  logic              r_meas_valid;
  logic              r_locked;
  logic              r_err_period;
  logic              r_err_duty;
  logic              r_err_stuck;

  // Next-state / next-value wires
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  w_per_cnt_nxt;
  logic [CNT_W-1:0]  w_hi_cnt_nxt;
  logic [GOOD_W-1:0] w_good_cnt_nxt;
  logic [CNT_W-1:0]  w_period_nxt;
  logic [CNT_W-1:0]  w_high_time_nxt;
  logic              w_meas_valid_nxt;
  logic              w_locked_nxt;
  logic              w_err_period_nxt;
  logic              w_err_duty_nxt;
  logic              w_err_stuck_nxt;
  logic              w_set_period;
  logic              w_set_duty;
  logic              w_set_stuck;

  // Edge detect and saturating increments
  logic             w_rise;
  logic [CNT_W-1:0] w_per_inc;
  logic [CNT_W-1:0] w_hi_inc;
  logic             w_per_good;
  logic             w_duty_good;
  logic             w_timeout;

  assign w_rise      = r_s2 & ~r_s3;
  assign w_per_inc   = (r_per_cnt == CNT_MAX) ? r_per_cnt : r_per_cnt + CNT_W'(1);
  assign w_hi_inc    = (r_hi_cnt == CNT_MAX) ? r_hi_cnt : r_hi_cnt + CNT_W'(1);
  assign w_per_good  = (r_per_cnt == EXP_P);
  // +/- half-cycle window absorbs the half-cycle edge of odd-ratio dividers
  assign w_duty_good = (r_hi_cnt == HI_LO) || (r_hi_cnt == HI_HI);
  // per_cnt saturates, so a dead input keeps re-triggering after a clear
  assign w_timeout   = (r_per_cnt >= TMO);

  // Next-state and datapath update
  always_comb begin
    w_state_nxt      = r_state;
    w_per_cnt_nxt    = r_per_cnt;
    w_hi_cnt_nxt     = r_hi_cnt;
    w_good_cnt_nxt   = r_good_cnt;
    w_period_nxt     = r_period;
    w_high_time_nxt  = r_high_time;
    w_meas_valid_nxt = 1'b0;
    w_set_period     = 1'b0;
    w_set_duty       = 1'b0;
    w_set_stuck      = 1'b0;

    if (!meas_en) begin
      w_state_nxt    = ST_IDLE;
      w_per_cnt_nxt  = '0;
      w_hi_cnt_nxt   = '0;
      w_good_cnt_nxt = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt    = ST_WAIT_EDGE;
          w_per_cnt_nxt  = '0;
          w_hi_cnt_nxt   = '0;
          w_good_cnt_nxt = '0;
        end
        ST_WAIT_EDGE, ST_MEASURE: begin
          if (w_rise) begin
            w_per_cnt_nxt = CNT_W'(1);
            w_hi_cnt_nxt  = CNT_W'(1);
            if (r_state == ST_MEASURE) begin
              w_period_nxt     = r_per_cnt;
              w_high_time_nxt  = r_hi_cnt;
              w_meas_valid_nxt = 1'b1;
              if (w_per_good && w_duty_good) begin
                if (r_good_cnt != GOOD_MAX) begin
                  w_good_cnt_nxt = r_good_cnt + GOOD_W'(1);
                end
              end else begin
                w_good_cnt_nxt = '0;
                w_set_period   = ~w_per_good;
                w_set_duty     = ~w_duty_good;
              end
            end else begin
              // first edge only opens the window; partial period discarded
              w_state_nxt = ST_MEASURE;
            end
          end else begin
            w_per_cnt_nxt = w_per_inc;
            if (r_s2) begin
              w_hi_cnt_nxt = w_hi_inc;
            end
            if (w_timeout) begin
              w_set_stuck    = 1'b1;
              w_good_cnt_nxt = '0;
              w_state_nxt    = ST_WAIT_EDGE;
            end
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end

    w_locked_nxt     = (w_good_cnt_nxt == GOOD_MAX);
    // set wins over a simultaneous clear
    w_err_period_nxt = (r_err_period & ~err_clr) | w_set_period;
    w_err_duty_nxt   = (r_err_duty & ~err_clr) | w_set_duty;
    w_err_stuck_nxt  = (r_err_stuck & ~err_clr) | w_set_stuck;
  end

  // State and datapath registers
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_s1         <= 1'b0;
      r_s2         <= 1'b0;
      r_s3         <= 1'b0;
      r_state      <= ST_IDLE;
      r_per_cnt    <= '0;
      r_hi_cnt     <= '0;
      r_good_cnt   <= '0;
      r_period     <= '0;
      r_high_time  <= '0;
      r_meas_valid <= 1'b0;
      r_locked     <= 1'b0;
      r_err_period <= 1'b0;
      r_err_duty   <= 1'b0;
      r_err_stuck  <= 1'b0;
    end else begin
      r_s1         <= clk_in;
      r_s2         <= r_s1;
      r_s3         <= r_s2;
      r_state      <= w_state_nxt;
      r_per_cnt    <= w_per_cnt_nxt;
      r_hi_cnt     <= w_hi_cnt_nxt;
      r_good_cnt   <= w_good_cnt_nxt;
      r_period     <= w_period_nxt;
      r_high_time  <= w_high_time_nxt;
      r_meas_valid <= w_meas_valid_nxt;
      r_locked     <= w_locked_nxt;
      r_err_period <= w_err_period_nxt;
      r_err_duty   <= w_err_duty_nxt;
      r_err_stuck  <= w_err_stuck_nxt;
    end
  end

  assign period     = r_period;
  assign high_time  = r_high_time;
  assign meas_valid = r_meas_valid;
  assign locked     = r_locked;
  assign err_period = r_err_period;
  assign err_duty   = r_err_duty;
  assign err_stuck  = r_err_stuck;

endmodule
